// File: rtl/ifetch_pkg.sv
// Shared widths and the {pc, inst} entry type for the instruction fetch stage.
package ifetch_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Circular FIFO of fetch entries; depth need not be a power of two.
// Flush discards everything and wins over a same-cycle push.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= ptr_inc(tail_ptr);
      if (do_pop)  head_ptr <= ptr_inc(head_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= wr_entry;
  end

  assign head = empty ? '0 : mem[head_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC register driving the ROM address, entry queue toward decode,
// and redirect handling that flushes the queue and reloads the PC.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  output logic [XLEN-1:0]   HADDR,
  output logic [XLEN-1:0]   HWDATA,
  input  logic [XLEN-1:0]   HRDATA,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  logic [XLEN-1:0] fetch_pc;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;
  logic            unused_in_bits;

  assign pop  = inst_valid & inst_ready;
  assign push = ~redirect_valid & (~q_full | pop);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  assign wr_entry.pc   = fetch_pc;
  assign wr_entry.inst = HRDATA[INST_W-1:0];

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head_entry),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign HADDR      = fetch_pc;
  assign HWDATA     = '0;
  assign inst_valid = ~q_empty;
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;

  // Upper ROM data half and the redirect byte offset carry no meaning here.
  assign unused_in_bits = ^{HRDATA[XLEN-1:INST_W], redirect_pc[1:0]};

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: expected {pc, inst} pairs are queued when
// a fetch stream starts and compared as decode accepts entries.
module tb_ifetch_unit;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int p0;
  logic [95:0] exp_q [$];

  ifetch_unit #(
    .RESET_PC    (64'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HADDR          (HADDR),
    .HWDATA         (HWDATA),
    .HRDATA         (HRDATA),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] rom_inst(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h0180_3083;
      64'd4:   return 32'h0010_8093;
      64'd8:   return 32'h0010_8113;
      64'd12:  return 32'h0011_0133;
      default: return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endcase
  endfunction

  // Upper half is junk that the DUT must ignore.
  assign HRDATA = {~HADDR[31:0], rom_inst(HADDR)};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_stream(input logic [63:0] start);
    logic [63:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({pc, rom_inst(pc)});
      pc = pc + 64'd4;
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (inst_valid && inst_ready) begin
      logic [95:0] e;
      pops++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e[95:32]);
        chk("sb_inst", {32'h0, inst_data}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    HRESETn        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    inst_ready     = 1'b0;
    #12;
    chk("rst_valid", {63'h0, inst_valid}, 64'd0);
    chk("rst_data", {32'h0, inst_data}, 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_haddr", HADDR, 64'd0);
    chk("rst_hwdata", HWDATA, 64'd0);

    // Streaming with decode always ready.
    inst_ready = 1'b1;
    start_stream(64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("rel_valid_pre", {63'h0, inst_valid}, 64'd0);
    tick();
    chk("rel_valid_first", {63'h0, inst_valid}, 64'd1);
    chk("rel_pc_first", inst_pc, 64'd0);
    p0 = pops;
    repeat (4) tick();
    chk("stream_count", 64'(pops - p0), 64'd4);

    // Back-pressure fills the queue, then drains without gaps.
    HRESETn    = 1'b0;
    inst_ready = 1'b0;
    start_stream(64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_head_pc", inst_pc, 64'd0);
    end
    chk("bp_haddr", HADDR, 64'd8);
    chk("bp_valid", {63'h0, inst_valid}, 64'd1);
    inst_ready = 1'b1;
    p0 = pops;
    repeat (3) tick();
    chk("bp_drain_count", 64'(pops - p0), 64'd3);

    // Misaligned redirect with two entries queued.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0D;
    @(negedge HCLK);
    #1;
    start_stream(64'h0C);
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid_t1", {63'h0, inst_valid}, 64'd0);
    chk("rd_haddr_t1", HADDR, 64'h0C);
    tick();
    chk("rd_valid_t2", {63'h0, inst_valid}, 64'd1);
    chk("rd_pc_t2", inst_pc, 64'h0C);
    repeat (2) tick();

    // Redirect coinciding with a pop from a full queue.
    inst_ready = 1'b0;
    repeat (3) tick();
    chk("rp_full_valid", {63'h0, inst_valid}, 64'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    p0 = pops;
    @(negedge HCLK);
    #1;
    chk("rp_pop_taken", 64'(pops - p0), 64'd1);
    start_stream(64'h100);
    tick();
    redirect_valid = 1'b0;
    chk("rp_valid_t1", {63'h0, inst_valid}, 64'd0);
    tick();
    chk("rp_pc_t2", inst_pc, 64'h100);
    repeat (3) tick();

    // Held redirect near the top of the address space, then wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge HCLK);
    #1;
    start_stream(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wr_haddr_h1", HADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_valid_h1", {63'h0, inst_valid}, 64'd0);
    tick();
    chk("wr_haddr_h2", HADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_valid_h2", {63'h0, inst_valid}, 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("wr_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_haddr_wrap", HADDR, 64'd0);
    tick();
    chk("wr_pc_zero", inst_pc, 64'd0);
    repeat (2) tick();

    // Asynchronous reset between edges.
    #2;
    HRESETn = 1'b0;
    #1;
    chk("ar_valid", {63'h0, inst_valid}, 64'd0);
    chk("ar_haddr", HADDR, 64'd0);
    chk("ar_pc", inst_pc, 64'd0);
    chk("ar_data", {32'h0, inst_data}, 64'd0);
    start_stream(64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    chk("ar_restart_pc", inst_pc, 64'd0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
